// File: rtl/anycore_l15_pkg.sv
// anycore_l15_pkg
// Shared definitions for the Anycore <-> L1.5 transducer return path.
//   - Line / beat widths for the Anycore I-cache and D-cache fill ports.
//   - L1.5 return-type codes (values match OpenPiton iop.h).
//   - Encoder FSM state encoding.
//   - Big-endian to little-endian 64-bit byte swap.
package anycore_l15_pkg;

  localparam int IC_LINE_W = 256;
  localparam int DC_LINE_W = 256;
  localparam int LD_BEAT_W = 128;
  localparam int DC_BEATS  = DC_LINE_W / LD_BEAT_W;

  // L1.5 return types (iop.h)
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] EVICT_REQ = 4'b0011;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  typedef enum logic {
    ENC_IDLE       = 1'b0,
    ENC_LD_COLLECT = 1'b1
  } enc_state_e;

  // Byte 0 of the result is byte 7 of the input, and so on.
  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = w[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/anycore_dc_line_assembler.sv
// anycore_dc_line_assembler
// Collects LOAD_RET beats into one D-cache line.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   beat_valid     a LOAD_RET beat is being consumed this cycle
//   beat_nc        the beat is noncacheable (single-beat line, upper part zero)
//   beat_data      byte-swapped beat payload
//   line_done      combinational: this beat completes a line
//   line_data      combinational: the completed line (valid with line_done)
//   beat_cnt       index of the next beat slot to be filled
import anycore_l15_pkg::*;

module anycore_dc_line_assembler (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 beat_valid,
  input  logic                 beat_nc,
  input  logic [LD_BEAT_W-1:0] beat_data,
  output logic                 line_done,
  output logic [DC_LINE_W-1:0] line_data,
  output logic [((DC_BEATS > 1) ? $clog2(DC_BEATS) : 1)-1:0] beat_cnt
);

  localparam int CNT_W = (DC_BEATS > 1) ? $clog2(DC_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DC_BEATS - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DC_LINE_W-1:0] line_q, line_d;

  always_comb begin
    cnt_d     = cnt_q;
    line_d    = line_q;
    line_done = 1'b0;
    line_data = line_q;
    if (beat_valid) begin
      if (beat_nc) begin
        // Noncacheable loads are standalone: they complete at once and leave
        // any partially collected cacheable line untouched.
        line_done = 1'b1;
        line_data = {{(DC_LINE_W-LD_BEAT_W){1'b0}}, beat_data};
      end else begin
        line_d[int'(cnt_q)*LD_BEAT_W +: LD_BEAT_W] = beat_data;
        line_data = line_d;
        if (cnt_q == LAST_BEAT) begin
          line_done = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign beat_cnt = cnt_q;

endmodule

// File: rtl/anycore_response_encoder.sv
// anycore_response_encoder
// Return-path stage from the L1.5 transducer response interface to the
// Anycore I-cache / D-cache fill ports. Byte-swaps big-endian payload words,
// assembles two-beat D-cache lines and pulses the matching Anycore valid one
// cycle after the packet is acknowledged.
//
// Handshake: l15_transducer_val is held by the L1.5 until acknowledged;
// transducer_l15_req_ack is a combinational copy of val (gated off only while
// in reset), so every packet is consumed in the cycle it is presented.
// Anycore applies no backpressure.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   l15_transducer_*               L1.5 return packet (val, type, nc, data_0..3)
//   transducer_l15_req_ack         packet consumed this cycle
//   anycore_mem2ic_valid/_data     ifill pulse and line
//   anycore_mem2dc_ldvalid/_lddata load-fill pulse and line
//   anycore_mem2dc_stcomplete      store-ack pulse
//   anycore_int_pulse              interrupt pulse
//   enc_state                      current FSM state (debug)
//
// Build option: define ANYCORE_ENC_INT_FWD_EN to forward INT_RET as a
// one-cycle anycore_int_pulse; otherwise INT_RET is dropped and the pulse is 0.
import anycore_l15_pkg::*;

module anycore_response_encoder (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 l15_transducer_val,
  input  logic [3:0]           l15_transducer_returntype,
  input  logic                 l15_transducer_noncacheable,
  input  logic [63:0]          l15_transducer_data_0,
  input  logic [63:0]          l15_transducer_data_1,
  input  logic [63:0]          l15_transducer_data_2,
  input  logic [63:0]          l15_transducer_data_3,
  output logic                 transducer_l15_req_ack,
  output logic                 anycore_mem2ic_valid,
  output logic [IC_LINE_W-1:0] anycore_mem2ic_data,
  output logic                 anycore_mem2dc_ldvalid,
  output logic [DC_LINE_W-1:0] anycore_mem2dc_lddata,
  output logic                 anycore_mem2dc_stcomplete,
  output logic                 anycore_int_pulse,
  output enc_state_e           enc_state
);

  localparam int CNT_W = (DC_BEATS > 1) ? $clog2(DC_BEATS) : 1;

  enc_state_e state_q, state_d;

  logic                 fire;
  logic                 ifill_fire, st_fire, load_fire;
  logic [63:0]          sw0, sw1, sw2, sw3;
  logic                 line_done;
  logic [DC_LINE_W-1:0] line_data;
  logic [CNT_W-1:0]     beat_cnt;

  assign fire       = l15_transducer_val && rst_n;
  assign ifill_fire = fire && (l15_transducer_returntype == IFILL_RET);
  assign st_fire    = fire && (l15_transducer_returntype == ST_ACK);
  assign load_fire  = fire && (l15_transducer_returntype == LOAD_RET);

  assign transducer_l15_req_ack = fire;

  assign sw0 = bswap64(l15_transducer_data_0);
  assign sw1 = bswap64(l15_transducer_data_1);
  assign sw2 = bswap64(l15_transducer_data_2);
  assign sw3 = bswap64(l15_transducer_data_3);

  anycore_dc_line_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_valid (load_fire),
    .beat_nc    (l15_transducer_noncacheable),
    .beat_data  ({sw1, sw0}),
    .line_done  (line_done),
    .line_data  (line_data),
    .beat_cnt   (beat_cnt)
  );

  // FSM tracks whether a cacheable line is partially collected. IFILL/ST_ACK
  // and noncacheable loads may interleave without leaving LD_COLLECT.
  always_comb begin
    state_d = state_q;
    if (load_fire && !l15_transducer_noncacheable) begin
      state_d = line_done ? ENC_IDLE : ENC_LD_COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ENC_IDLE;
    else        state_q <= state_d;
  end

  assign enc_state = state_q;

  // Output registers: valids are one-cycle pulses, data holds between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anycore_mem2ic_valid      <= 1'b0;
      anycore_mem2ic_data       <= '0;
      anycore_mem2dc_ldvalid    <= 1'b0;
      anycore_mem2dc_lddata     <= '0;
      anycore_mem2dc_stcomplete <= 1'b0;
    end else begin
      anycore_mem2ic_valid      <= ifill_fire;
      anycore_mem2dc_ldvalid    <= line_done;
      anycore_mem2dc_stcomplete <= st_fire;
      if (ifill_fire) anycore_mem2ic_data <= {sw3, sw2, sw1, sw0};
      if (line_done)  anycore_mem2dc_lddata <= line_data;
    end
  end

`ifdef ANYCORE_ENC_INT_FWD_EN
  logic int_q;
  always_ff @(posedge clk) begin
    if (!rst_n) int_q <= 1'b0;
    else        int_q <= fire && (l15_transducer_returntype == INT_RET);
  end
  assign anycore_int_pulse = int_q;
`else
  assign anycore_int_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_anycore_response_encoder.sv
import anycore_l15_pkg::*;

module tb_anycore_response_encoder;

  localparam int W = 4 + 256;   // {int, ic, ld, st, data}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         val = 1'b0;
  logic [3:0]   rtype = '0;
  logic         nc = 1'b0;
  logic [63:0]  d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic         ack;
  logic         ic_valid;
  logic [255:0] ic_data;
  logic         ld_valid;
  logic [255:0] ld_data;
  logic         st_complete;
  logic         int_pulse;
  enc_state_e   st_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed test words and their byte-swapped forms
  localparam logic [63:0] A1 = 64'h1122334455667788, A1S = 64'h8877665544332211;
  localparam logic [63:0] A2 = 64'h0011223344556677, A2S = 64'h7766554433221100;
  localparam logic [63:0] B1 = 64'hdeadbeefcafef00d, B1S = 64'h0df0fecaefbeadde;
  localparam logic [63:0] B2 = 64'h0123456789abcdef, B2S = 64'hefcdab8967452301;

  localparam logic [3:0] K_INT = 4'b1000, K_IC = 4'b0100, K_LD = 4'b0010, K_ST = 4'b0001;

  anycore_response_encoder dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .l15_transducer_val          (val),
    .l15_transducer_returntype   (rtype),
    .l15_transducer_noncacheable (nc),
    .l15_transducer_data_0       (d0),
    .l15_transducer_data_1       (d1),
    .l15_transducer_data_2       (d2),
    .l15_transducer_data_3       (d3),
    .transducer_l15_req_ack      (ack),
    .anycore_mem2ic_valid        (ic_valid),
    .anycore_mem2ic_data         (ic_data),
    .anycore_mem2dc_ldvalid      (ld_valid),
    .anycore_mem2dc_lddata       (ld_data),
    .anycore_mem2dc_stcomplete   (st_complete),
    .anycore_int_pulse           (int_pulse),
    .enc_state                   (st_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_pulse(input logic [3:0] kind, input logic [255:0] data);
    exp_q.push_back({kind, data});
  endtask

  // ---------------- driver ----------------
  // Called just after a posedge; presents the packet for one cycle and
  // checks the same-cycle ack.
  task automatic send(input logic [3:0] t, input logic n,
                      input logic [63:0] w0, input logic [63:0] w1,
                      input logic [63:0] w2, input logic [63:0] w3);
    val = 1'b1; rtype = t; nc = n;
    d0 = w0; d1 = w1; d2 = w2; d3 = w3;
    #1;
    check("ack_with_val", {255'b0, ack}, 256'd1);
    @(posedge clk); #1;
    val = 1'b0; rtype = 4'hf; nc = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] obs, exp;
    if (ic_valid || ld_valid || st_complete || int_pulse) begin
      obs = {int_pulse, ic_valid, ld_valid, st_complete,
             ic_valid ? ic_data : (ld_valid ? ld_data : 256'b0)};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse actual=%h required=none", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL pulse actual=%h required=%h", obs, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset: ack must stay low in reset even with val high.
    val = 1'b1; rtype = LOAD_RET;
    repeat (2) @(posedge clk);
    #1;
    check("ack_in_reset", {255'b0, ack}, 256'd0);
    val = 1'b0; rtype = 4'hf;
    check("rst_ic_valid", {255'b0, ic_valid}, 256'd0);
    check("rst_ld_valid", {255'b0, ld_valid}, 256'd0);
    check("rst_st_complete", {255'b0, st_complete}, 256'd0);
    check("rst_int_pulse", {255'b0, int_pulse}, 256'd0);
    check("rst_ic_data", ic_data, 256'd0);
    check("rst_ld_data", ld_data, 256'd0);
    check("rst_state", {255'b0, st_dbg}, 256'd0);
    rst_n = 1'b1;
    idle(1);
    check("ack_idle", {255'b0, ack}, 256'd0);

    // 1. IFILL with only data_0
    expect_pulse(K_IC, {192'b0, 64'h0807060504030201});
    send(IFILL_RET, 1'b0, 64'h0102030405060708, 64'h0, 64'h0, 64'h0);
    idle(2);

    // 2. IFILL with four words: word k lands at bits [64k+63:64k]
    expect_pulse(K_IC, {B2S, B1S, A2S, A1S});
    send(IFILL_RET, 1'b0, A1, A2, B1, B2);
    idle(1);

    // 3. Two-beat cacheable load
    send(LOAD_RET, 1'b0, A1, A2, 64'h0, 64'h0);
    check("state_collect", {255'b0, st_dbg}, {255'b0, ENC_LD_COLLECT});
    expect_pulse(K_LD, {B2S, B1S, A2S, A1S});
    send(LOAD_RET, 1'b0, B1, B2, 64'h0, 64'h0);
    check("state_idle_after_line", {255'b0, st_dbg}, {255'b0, ENC_IDLE});
    idle(2);
    check("ic_data_holds", ic_data, {B2S, B1S, A2S, A1S});

    // 4. Beat 0, ST_ACK, IFILL interleaved, then beat 1
    send(LOAD_RET, 1'b0, B1, B2, 64'h0, 64'h0);
    expect_pulse(K_ST, 256'b0);
    send(ST_ACK, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    expect_pulse(K_IC, {192'b0, 64'h0807060504030201});
    send(IFILL_RET, 1'b0, 64'h0102030405060708, 64'h0, 64'h0, 64'h0);
    expect_pulse(K_LD, {A2S, A1S, B2S, B1S});
    send(LOAD_RET, 1'b0, A1, A2, 64'h0, 64'h0);
    idle(2);

    // 5. Noncacheable load: completes alone, upper half zero
    expect_pulse(K_LD, {128'b0, A2S, A1S});
    send(LOAD_RET, 1'b1, A1, A2, B1, B2);
    idle(2);
    check("nc_upper_zero", {128'b0, ld_data[255:128]}, 256'd0);

    // 6. Reset after beat 0 discards the partial line
    send(LOAD_RET, 1'b0, A1, A2, 64'h0, 64'h0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    check("state_after_reset", {255'b0, st_dbg}, {255'b0, ENC_IDLE});
    send(LOAD_RET, 1'b0, B1, B2, 64'h0, 64'h0);   // new beat 0: no pulse
    idle(2);
    expect_pulse(K_LD, {A2S, A1S, B2S, B1S});
    send(LOAD_RET, 1'b0, A1, A2, 64'h0, 64'h0);
    idle(2);

    // 7. INT_RET, EVICT_REQ and an unknown type: acked, no fill pulses
`ifdef ANYCORE_ENC_INT_FWD_EN
    expect_pulse(K_INT, 256'b0);
`endif
    send(INT_RET, 1'b0, A1, A2, B1, B2);
    send(EVICT_REQ, 1'b0, A1, A2, B1, B2);
    send(4'b1111, 1'b0, A1, A2, B1, B2);
    idle(4);

    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
